serial_sub: RTL and testbench

// - Bit-serial WIDTH-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
// - It is the inverse-direction companion to the team's ripple-carry adder.
// - It trades the adder's combinational ripple for one shared full-subtractor stage plus shift registers.
// - It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/serial_sub_full_sub1.sv | 14 +
 rtl/serial_sub.sv | 111 +++++++++++
 tb/tb_serial_sub.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
// Imported by the top level; holds the FSM encoding and width bounds.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam int MIN_WIDTH = 2;
   localparam int MAX_WIDTH = 32;

   function automatic bit width_ok(input int w);
      return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
   endfunction

endpackage

// File: rtl/serial_sub_full_sub1.sv
// One-bit combinational full subtractor.
// Shared by every bit position of the serial datapath.
module full_sub1 (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first.
// Valid/ready on both sides; one shared full-subtractor stage.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("serial_sub: WIDTH must be in 2..32");
      end
   endgenerate

   state_t           state;
   state_t           nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_sr;
   logic [WIDTH-1:0] diff_nxt;
   logic             brw;
   logic             zero_q;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             bo;
   logic             last;

   full_sub1 u_fs (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .bi (brw),
      .d  (d),
      .bo (bo)
   );

   assign last     = (cnt == CW'(WIDTH - 1));
   assign diff_nxt = {d, diff_sr[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (in_valid)  nxt = S_SHIFT;
         S_SHIFT: if (last)      nxt = S_DONE;
         S_DONE:  if (out_ready) nxt = S_IDLE;
         default:                nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         S_IDLE:  in_ready  = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Nothing shifts in DONE, so diff_sr/brw double as the held result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         brw     <= 1'b0;
         zero_q  <= 1'b0;
         cnt     <= '0;
      end else if (state == S_IDLE) begin
         if (in_valid) begin
            a_sr    <= a;
            b_sr    <= b;
            brw     <= bin;
            diff_sr <= '0;
            zero_q  <= 1'b0;
            cnt     <= '0;
         end
      end else if (state == S_SHIFT) begin
         a_sr    <= a_sr >> 1;
         b_sr    <= b_sr >> 1;
         brw     <= bo;
         diff_sr <= diff_nxt;
         if (last) zero_q <= (diff_nxt == '0) && !bo;
         else      cnt    <= cnt + CW'(1);
      end
   end

   assign diff = diff_sr;
   assign bout = brw;
   assign zero = zero_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH = 4.
// Directed table, hand-written corner sequences, random back-to-back run.
module tb_serial_sub;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         zero;

   int vectors     = 0;
   int miscompares = 0;

   serial_sub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
      logic         zero;
   } vec_t;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         zero;
   } res_t;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer subtraction, borrow = result went negative.
   function automatic res_t model(input logic [W-1:0] ma,
                                  input logic [W-1:0] mb,
                                  input logic mbin);
      res_t r;
      int   t;
      t      = int'(ma) - int'(mb) - int'(mbin);
      r.diff = W'(t & ((1 << W) - 1));
      r.bout = (t < 0);
      r.zero = (r.diff == 0) && !r.bout;
      return r;
   endfunction

   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tbin);
      int n = 0;
      while (!in_ready && n < 30) begin
         tick();
         n++;
      end
      if (n == 30) check("in_ready_timeout", 32'(in_ready), 32'd1);
      a        = ta;
      b        = tb;
      bin      = tbin;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a        = ~ta;
      b        = ~tb;
      bin      = ~tbin;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_handshake_in_ready", 32'(in_ready), 32'd1);
   endtask

   vec_t vecs [9];

   initial begin
      res_t q[$];
      res_t exp_r;
      int   lat;
      int   cyc;
      int   last_acc;
      int   done_cnt;
      logic seen;

      vecs[0] = '{4'd9,  4'd3,  1'b0, 4'h6, 1'b0, 1'b0};
      vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA, 1'b1, 1'b0};
      vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0};
      vecs[3] = '{4'd5,  4'd5,  1'b0, 4'h0, 1'b0, 1'b1};
      vecs[4] = '{4'd0,  4'd1,  1'b0, 4'hF, 1'b1, 1'b0};
      vecs[5] = '{4'd15, 4'd0,  1'b0, 4'hF, 1'b0, 1'b0};
      vecs[6] = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0};
      vecs[7] = '{4'd0,  4'd15, 1'b1, 4'h0, 1'b1, 1'b0};
      vecs[8] = '{4'd8,  4'd1,  1'b1, 4'h6, 1'b0, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      tick();
      tick();
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff",      32'(diff),      32'd0);
      check("rst_bout",      32'(bout),      32'd0);
      check("rst_zero",      32'(zero),      32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
         wait_done(lat);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
         check($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].diff));
         check($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
         check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
         finish_op();
      end

      // Back-pressure: result frozen, new operands ignored.
      start_op(4'd7, 4'd2, 1'b0);
      wait_done(lat);
      in_valid = 1'b1;
      a        = 4'd0;
      b        = 4'd9;
      for (int i = 0; i < 10; i++) begin
         check("bp_diff",      32'(diff),      32'd5);
         check("bp_in_ready",  32'(in_ready),  32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("bp_release_idle", 32'(in_ready),  32'd1);
      check("bp_release_ov",   32'(out_valid), 32'd0);

      // Reset mid-operation.
      start_op(4'd12, 4'd3, 1'b0);
      tick();
      rst_n = 1'b0;
      tick();
      check("mid_rst_in_ready", 32'(in_ready),  32'd1);
      check("mid_rst_ov",       32'(out_valid), 32'd0);
      check("mid_rst_diff",     32'(diff),      32'd0);
      check("mid_rst_bout",     32'(bout),      32'd0);
      check("mid_rst_zero",     32'(zero),      32'd0);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      check("mid_rst_no_result", 32'(seen), 32'd0);
      start_op(4'd8, 4'd1, 1'b0);
      wait_done(lat);
      check("after_rst_latency", 32'(lat),  32'd4);
      check("after_rst_diff",    32'(diff), 32'd7);
      check("after_rst_bout",    32'(bout), 32'd0);
      finish_op();

      // Random back-to-back stream.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cyc       = 0;
      last_acc  = -1;
      done_cnt  = 0;
      while (done_cnt < 200 && cyc < 2000) begin
         a   = W'($urandom);
         b   = W'($urandom);
         bin = 1'($urandom);
         if (in_ready) begin
            q.push_back(model(a, b, bin));
            if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               check("b2b_unexpected_result", 32'(out_valid), 32'd0);
            end else begin
               exp_r = q.pop_front();
               check("b2b_result", {27'd0, zero, bout, diff},
                     {27'd0, exp_r.zero, exp_r.bout, exp_r.diff});
            end
            done_cnt++;
         end
         tick();
         cyc++;
      end
      check("b2b_count", 32'(done_cnt), 32'd200);
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
